m_mem_arbiter: RTL and testbench
================================

# m_mem_arbiter

Two-port arbiter and sequencer that shares one single-port, fixed-latency memory between the instruction-fetch stage and the memory-access stage of the pipelined core. It serves one request at a time, drives the memory command registered, and returns a one-cycle acknowledge with read data. The pipeline treats `!ack` on a pending request as its stall condition. It sits between the IF/MA stages and the unified memory macro.

## Interface
- ADDR_W, 32, address width of all ports
- DATA_W, 32, data width of all ports
- LAT, 1, memory read latency in cycles from the `w_m_en` cycle to valid `w_m_rdata`; legal range 1..15
- w_clock  in  1  clock, all state updates on posedge
- w_reset  in  1  synchronous, active-high reset
- w_i_req  in  1  fetch request; held with `w_i_addr` stable until `w_i_ack`
- w_i_addr  in  ADDR_W  fetch address
- w_i_ack  out  1  one-cycle pulse: fetch done, `w_i_rdata` valid
- w_i_rdata  out  DATA_W  fetch read data, held until next fetch ack
- w_d_req  in  1  data request; held with address, we and wdata stable until `w_d_ack`
- w_d_we  in  1  1 = write, 0 = read
- w_d_addr  in  ADDR_W  data address
- w_d_wdata  in  DATA_W  write data
- w_d_ack  out  1  one-cycle pulse: data access done; `w_d_rdata` valid for reads
- w_d_rdata  out  DATA_W  data read data, held until next data read ack
- w_m_en  out  1  memory command strobe, registered, high exactly one cycle per access
- w_m_we  out  1  memory write enable, qualified by `w_m_en`
- w_m_addr  out  ADDR_W  memory address, registered
- w_m_wdata  out  DATA_W  memory write data, registered
- w_m_rdata  in  DATA_W  memory read data, valid LAT cycles after the `w_m_en` cycle
- w_busy  out  1  high whenever state is not IDLE

## Operation
- FSM states are IDLE, ISSUE, WAIT and DONE. The grant register `r_gnt` records the winner: 0 = fetch, 1 = data.
- IDLE: if either request is high, arbitrate, latch the winner's command into the `w_m_*` registers and go to ISSUE. Otherwise stay in IDLE.
- ISSUE: `w_m_en` is high for this cycle only.
  - Write: go to DONE.
  - Read: load a 4-bit counter with LAT-1 and go to WAIT.
- WAIT: decrement the counter each cycle. When the counter is 0, capture `w_m_rdata` into the granted port's rdata register and go to DONE.
- DONE: pulse the granted port's ack, then go to IDLE unconditionally. Requests are not sampled in DONE because the requester's inputs are still the acknowledged ones.
- Only the granted port's rdata register is updated. The other port's rdata keeps its value.
- The non-granted port's request stays pending. It is re-arbitrated in the next IDLE.
- The memory-side outputs hold their last values when `w_m_en` is low. `w_m_we` is forced to 0 outside ISSUE.
- Default arbitration is fixed priority: data beats fetch on a tie, so an older instruction's memory access completes first. Fetch can starve while `w_d_req` is held high continuously.

## Timing
- Cycle 0 is the IDLE cycle in which a request is sampled.
- `w_m_en` is high in cycle 1.
- Write ack is in cycle 2.
- Read data is captured at the end of cycle LAT+1. Read ack is in cycle LAT+2.
- Back-to-back throughput: one write per 3 cycles, one read per LAT+3 cycles, because DONE→IDLE costs one cycle.
- Reset: `w_reset` high at a posedge forces state IDLE and counter 0. All outputs are 0 from the next cycle: `w_i_ack`, `w_d_ack`, `w_m_en`, `w_m_we`, `w_busy`, every address, wdata and rdata register, and `r_gnt`.
- Reset mid-access abandons the transaction. No ack is issued, and late `w_m_rdata` is ignored.
- Reset has priority over every transition.
- An ack pulse never coincides with `w_m_en`.
- At most one of `w_i_ack` and `w_d_ack` is high in any cycle.

## Configuration
- `M_MEM_ARB_RR_EN` defined: round-robin tie-break.
  - Register `r_last` holds the last granted port and resets to fetch.
  - On a tie, the port not granted last wins, so data wins the first tie after reset.
  - A lone requester always wins.
- Not defined: fixed data-over-fetch priority as described in Operation. `r_last` is not implemented.

## Test plan
- Reset: hold `w_reset` 2 cycles with both requests high → all outputs 0, `w_busy`=0, no `w_m_en`.
- Fetch read, LAT=2: `w_i_req`=1, addr 0x40 in cycle 0, memory drives 0x00000013 in cycle 3 → `w_m_en`/addr 0x40 only in cycle 1, `w_i_ack` only in cycle 4 with `w_i_rdata`=0x13, `w_d_ack` never high.
- Data write: `w_d_we`=1, addr 0x8, wdata 0xDEADBEEF in cycle 0 → cycle 1 has `w_m_en`=`w_m_we`=1, addr 0x8, wdata 0xDEADBEEF; `w_d_ack` in cycle 2; `w_d_rdata` unchanged.
- Tie, LAT=1, fixed priority: data read 0x10 and fetch 0x20 both requested in cycle 0 → data `w_m_en` cycle 1, `w_d_ack` cycle 3; fetch `w_m_en` cycle 5, `w_i_ack` cycle 7.
- Tie, `M_MEM_ARB_RR_EN`: three consecutive tie rounds of writes → grants D, I, D. Without the macro: D, D, D, with `w_i_ack` absent while `w_d_req` is held.
- Reset mid-read, LAT=4: assert `w_reset` in cycle 3 → no ack, `w_m_rdata` in cycle 5 ignored, `w_i_rdata`=0. A new fetch issued after reset completes with the normal LAT+2 latency.

Source files
------------

// File: rtl/m_mem_arbiter.sv
// m_mem_arbiter
// Shares one single-port, fixed-latency memory between the instruction-fetch
// port (i) and the memory-access port (d). One access is in flight at a time.
// The memory command is registered, and each access finishes with a one-cycle
// acknowledge pulse on the port that was granted.
//
// Optional build macro:
//   M_MEM_ARB_RR_EN - when defined, a tie goes to the port that was not
//                     granted last (round-robin). When undefined, data
//                     always beats fetch on a tie.
module m_mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LAT    = 1
) (
  input  logic              w_clock,
  input  logic              w_reset,
  input  logic              w_i_req,
  input  logic [ADDR_W-1:0] w_i_addr,
  output logic              w_i_ack,
  output logic [DATA_W-1:0] w_i_rdata,
  input  logic              w_d_req,
  input  logic              w_d_we,
  input  logic [ADDR_W-1:0] w_d_addr,
  input  logic [DATA_W-1:0] w_d_wdata,
  output logic              w_d_ack,
  output logic [DATA_W-1:0] w_d_rdata,
  output logic              w_m_en,
  output logic              w_m_we,
  output logic [ADDR_W-1:0] w_m_addr,
  output logic [DATA_W-1:0] w_m_wdata,
  input  logic [DATA_W-1:0] w_m_rdata,
  output logic              w_busy
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Counter reload: the ISSUE cycle already accounts for one cycle of latency.
  localparam logic [3:0] LAT_M1 = 4'(LAT - 1);

  state_t     state_reg;
  logic [3:0] cnt_reg;
  logic       r_gnt;      // 0 = fetch, 1 = data
  logic       gnt_next;   // winner of the arbitration performed in IDLE

`ifdef M_MEM_ARB_RR_EN
  logic r_last;           // port granted most recently, 0 = fetch

  // Round-robin tie-break; a lone requester always wins.
  always_comb begin
    gnt_next = w_d_req;
    if (w_d_req && w_i_req) begin
      gnt_next = ~r_last;
    end
  end

  // Remember the winner of every grant so the next tie goes the other way.
  always_ff @(posedge w_clock) begin
    if (w_reset) begin
      r_last <= 1'b0;
    end else if (state_reg == ST_IDLE && (w_i_req || w_d_req)) begin
      r_last <= gnt_next;
    end
  end
`else
  // Fixed priority: the data port wins whenever it requests.
  always_comb begin
    gnt_next = w_d_req;
  end
`endif

  assign w_busy = (state_reg != ST_IDLE);

  // Sequencer: arbitrate, issue one registered command, wait out the memory
  // latency for reads, then pulse the granted port's acknowledge.
  always_ff @(posedge w_clock) begin
    if (w_reset) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= 4'd0;
      r_gnt     <= 1'b0;
      w_i_ack   <= 1'b0;
      w_d_ack   <= 1'b0;
      w_i_rdata <= '0;
      w_d_rdata <= '0;
      w_m_en    <= 1'b0;
      w_m_we    <= 1'b0;
      w_m_addr  <= '0;
      w_m_wdata <= '0;
    end else begin
      // Strobes are single-cycle; the write enable is only ever high in ISSUE.
      w_i_ack <= 1'b0;
      w_d_ack <= 1'b0;
      w_m_en  <= 1'b0;
      w_m_we  <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (w_i_req || w_d_req) begin
            r_gnt  <= gnt_next;
            w_m_en <= 1'b1;
            if (gnt_next) begin
              w_m_we    <= w_d_we;
              w_m_addr  <= w_d_addr;
              w_m_wdata <= w_d_wdata;
            end else begin
              // Fetch is always a read; the write data register keeps its value.
              w_m_addr  <= w_i_addr;
            end
            state_reg <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (w_m_we) begin
            w_d_ack   <= r_gnt;
            w_i_ack   <= ~r_gnt;
            state_reg <= ST_DONE;
          end else begin
            cnt_reg   <= LAT_M1;
            state_reg <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (cnt_reg == 4'd0) begin
            if (r_gnt) begin
              w_d_rdata <= w_m_rdata;
              w_d_ack   <= 1'b1;
            end else begin
              w_i_rdata <= w_m_rdata;
              w_i_ack   <= 1'b1;
            end
            state_reg <= ST_DONE;
          end else begin
            cnt_reg <= cnt_reg - 4'd1;
          end
        end
        ST_DONE: begin
          // The requester still shows the acknowledged request here, so
          // arbitration waits for the next IDLE.
          state_reg <= ST_IDLE;
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_m_mem_arbiter.sv
// Testbench for m_mem_arbiter. Drivers issue random fetch/data transactions and
// push the expected outcome into per-port queues; a monitor checks every memory
// command and acknowledge against those queues and the arbitration rules.
module tb_m_mem_arbiter;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int LAT    = 2;

  logic              w_clock;
  logic              w_reset;
  logic              w_i_req;
  logic [ADDR_W-1:0] w_i_addr;
  logic              w_i_ack;
  logic [DATA_W-1:0] w_i_rdata;
  logic              w_d_req;
  logic              w_d_we;
  logic [ADDR_W-1:0] w_d_addr;
  logic [DATA_W-1:0] w_d_wdata;
  logic              w_d_ack;
  logic [DATA_W-1:0] w_d_rdata;
  logic              w_m_en;
  logic              w_m_we;
  logic [ADDR_W-1:0] w_m_addr;
  logic [DATA_W-1:0] w_m_wdata;
  logic [DATA_W-1:0] w_m_rdata;
  logic              w_busy;

  m_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LAT(LAT)) dut (
    .w_clock  (w_clock),
    .w_reset  (w_reset),
    .w_i_req  (w_i_req),
    .w_i_addr (w_i_addr),
    .w_i_ack  (w_i_ack),
    .w_i_rdata(w_i_rdata),
    .w_d_req  (w_d_req),
    .w_d_we   (w_d_we),
    .w_d_addr (w_d_addr),
    .w_d_wdata(w_d_wdata),
    .w_d_ack  (w_d_ack),
    .w_d_rdata(w_d_rdata),
    .w_m_en   (w_m_en),
    .w_m_we   (w_m_we),
    .w_m_addr (w_m_addr),
    .w_m_wdata(w_m_wdata),
    .w_m_rdata(w_m_rdata),
    .w_busy   (w_busy)
  );

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } txn_t;

  txn_t        iq[$];
  txn_t        dq[$];
  logic [31:0] ref_mem [logic [31:0]];  // scoreboard view of memory contents
  logic [31:0] bus_mem [logic [31:0]];  // memory macro model behind the DUT
  logic [31:0] due [int];               // read data keyed by the cycle it is valid

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  bit rst_q  = 1'b0;

  initial begin
    w_clock = 1'b0;
    forever #5 w_clock = ~w_clock;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Initial contents: fetch region 0x0..0xFC, data region 0x2000..0x201C.
  function automatic logic [31:0] init_val(input logic [31:0] a);
    return {~a[15:0], a[15:0]} ^ 32'h1357_0000;
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return init_val(a);
  endfunction

  function automatic logic [31:0] bus_rd(input logic [31:0] a);
    if (bus_mem.exists(a)) return bus_mem[a];
    return init_val(a);
  endfunction

  task automatic chk(input bit ok, input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Cycle counter and reset sample, taken at the active edge.
  initial begin
    forever begin
      @(posedge w_clock);
      cyc   = cyc + 1;
      rst_q = w_reset;
    end
  end

  // Memory macro: writes land on the command, reads return LAT cycles later;
  // every other cycle the read bus carries junk.
  initial begin
    w_m_rdata = '0;
    forever begin
      @(negedge w_clock);
      if (w_m_en === 1'b1) begin
        if (w_m_we === 1'b1) bus_mem[w_m_addr] = w_m_wdata;
        else                 due[cyc + LAT]   = bus_rd(w_m_addr);
      end
      if (due.exists(cyc)) w_m_rdata = due[cyc];
      else                 w_m_rdata = $urandom;
    end
  end

  // Monitor / scoreboard.
  initial begin
    bit          prev_i = 1'b0;
    bit          prev_d = 1'b0;
    bit          last_model = 1'b0;
    bit          out_valid = 1'b0;
    bit          out_port = 1'b0;
    int          out_cyc = 0;
    txn_t        out_t;
    logic [31:0] exp_i = '0;
    logic [31:0] exp_d = '0;
    forever begin
      @(negedge w_clock);
      if (rst_q) begin
        iq.delete();
        dq.delete();
        out_valid  = 1'b0;
        last_model = 1'b0;
        exp_i      = '0;
        exp_d      = '0;
        chk({w_i_ack, w_d_ack, w_m_en, w_m_we, w_busy} === 5'b0, "reset_ctl",
            {27'b0, w_i_ack, w_d_ack, w_m_en, w_m_we, w_busy}, 32'h0);
        chk((w_i_rdata | w_d_rdata | w_m_addr | w_m_wdata) === 32'h0, "reset_data",
            w_i_rdata | w_d_rdata | w_m_addr | w_m_wdata, 32'h0);
      end else begin
        chk(!(w_i_ack && w_d_ack) && !((w_i_ack || w_d_ack) && w_m_en), "ack_exclusive",
            {29'b0, w_i_ack, w_d_ack, w_m_en}, 32'h0);
        if (w_m_en === 1'b1) begin
          bit win;
          bit have;
          txn_t t;
`ifdef M_MEM_ARB_RR_EN
          win = (prev_i && prev_d) ? ~last_model : prev_d;
`else
          win = prev_d;
`endif
          if (!prev_i && !prev_d) begin
            chk(1'b0, "spurious_m_en", w_m_addr, 32'h0);
          end else if (out_valid) begin
            chk(1'b0, "m_en_overlap", w_m_addr, out_t.addr);
          end else begin
            have = win ? (dq.size() > 0) : (iq.size() > 0);
            chk(have, "m_en_no_request", {31'b0, win}, 32'h1);
            if (have) begin
              t = win ? dq[0] : iq[0];
              chk(w_m_addr === t.addr, "m_addr", w_m_addr, t.addr);
              chk(w_m_we === t.we, "m_we", {31'b0, w_m_we}, {31'b0, t.we});
              if (t.we) chk(w_m_wdata === t.wdata, "m_wdata", w_m_wdata, t.wdata);
              out_valid  = 1'b1;
              out_port   = win;
              out_cyc    = cyc;
              out_t      = t;
              last_model = win;
            end
          end
        end
        chk(w_busy === out_valid, "busy", {31'b0, w_busy}, {31'b0, out_valid});
        if (w_i_ack === 1'b1 || w_d_ack === 1'b1) begin
          if (!out_valid) begin
            chk(1'b0, "unexpected_ack", {30'b0, w_i_ack, w_d_ack}, 32'h0);
          end else begin
            chk(w_d_ack === out_port, "ack_port", {31'b0, w_d_ack}, {31'b0, out_port});
            chk((cyc - out_cyc) == (out_t.we ? 1 : LAT + 1), "ack_latency",
                32'(cyc - out_cyc), 32'(out_t.we ? 1 : LAT + 1));
            if (!out_t.we) begin
              if (out_port) exp_d = out_t.rdata;
              else          exp_i = out_t.rdata;
            end
            if (out_port && dq.size() > 0) void'(dq.pop_front());
            if (!out_port && iq.size() > 0) void'(iq.pop_front());
            $display("txn port=%s addr=%h we=%0d data=%h cycle=%0d", out_port ? "D" : "I",
                     out_t.addr, out_t.we, out_t.we ? out_t.wdata : out_t.rdata, cyc);
            out_valid = 1'b0;
          end
        end
        chk(w_i_rdata === exp_i, "i_rdata", w_i_rdata, exp_i);
        chk(w_d_rdata === exp_d, "d_rdata", w_d_rdata, exp_d);
      end
      prev_i = w_i_req;
      prev_d = w_d_req;
    end
  end

  task automatic wait_ack(input bit port);
    int n = 0;
    forever begin
      @(posedge w_clock);
      #1;
      if (port ? w_d_ack : w_i_ack) break;
      n++;
      if (n > 300) begin
        chk(1'b0, port ? "d_ack_timeout" : "i_ack_timeout", 32'(n), 32'h0);
        break;
      end
    end
  endtask

  task automatic drive_i(input int n, input int gap_max);
    for (int k = 0; k < n; k++) begin
      txn_t t;
      repeat ($urandom_range(0, gap_max)) @(posedge w_clock);
      #1;
      t.addr  = 32'(4 * $urandom_range(0, 63));
      t.we    = 1'b0;
      t.wdata = '0;
      t.rdata = ref_rd(t.addr);
      iq.push_back(t);
      w_i_addr = t.addr;
      w_i_req  = 1'b1;
      wait_ack(1'b0);
      w_i_req = 1'b0;
    end
  endtask

  task automatic drive_d(input int n, input int gap_max, input int we_mode);
    for (int k = 0; k < n; k++) begin
      txn_t t;
      repeat ($urandom_range(0, gap_max)) @(posedge w_clock);
      #1;
      t.addr  = 32'h2000 + 32'(4 * $urandom_range(0, 7));
      t.we    = (we_mode == 2) ? 1'($urandom_range(0, 1)) : 1'(we_mode);
      t.wdata = $urandom;
      t.rdata = ref_rd(t.addr);
      if (t.we) ref_mem[t.addr] = t.wdata;
      dq.push_back(t);
      w_d_addr  = t.addr;
      w_d_we    = t.we;
      w_d_wdata = t.wdata;
      w_d_req   = 1'b1;
      wait_ack(1'b1);
      w_d_req = 1'b0;
    end
  endtask

  initial begin
    // Reset held two cycles with both ports requesting.
    w_reset   = 1'b1;
    w_i_req   = 1'b1;
    w_i_addr  = 32'h40;
    w_d_req   = 1'b1;
    w_d_we    = 1'b1;
    w_d_addr  = 32'h2008;
    w_d_wdata = 32'hDEAD_BEEF;
    repeat (2) @(posedge w_clock);
    #1;
    w_reset = 1'b0;
    w_i_req = 1'b0;
    w_d_req = 1'b0;
    repeat (2) @(posedge w_clock);

    // Lone fetch read, then lone data write and read.
    drive_i(1, 0);
    drive_d(1, 0, 1);
    drive_d(1, 0, 0);
    repeat (2) @(posedge w_clock);

    // Tie rounds: writes on data while fetch stays pending, then mixed ties.
    @(posedge w_clock);
    fork
      drive_i(3, 0);
      drive_d(3, 0, 1);
    join
    repeat (2) @(posedge w_clock);
    @(posedge w_clock);
    fork
      drive_i(4, 0);
      drive_d(4, 0, 0);
    join

    // Random traffic.
    fork
      drive_i(40, 4);
      drive_d(40, 4, 2);
    join
    repeat (3) @(posedge w_clock);

    // Reset in the middle of a fetch read; late memory data must be ignored.
    @(posedge w_clock);
    #1;
    begin
      txn_t t;
      t.addr  = 32'h40;
      t.we    = 1'b0;
      t.wdata = '0;
      t.rdata = ref_rd(t.addr);
      iq.push_back(t);
      w_i_addr = t.addr;
      w_i_req  = 1'b1;
    end
    repeat (2) @(posedge w_clock);
    #1;
    w_reset = 1'b1;
    w_i_req = 1'b0;
    @(posedge w_clock);
    #1;
    w_reset = 1'b0;
    repeat (5) @(posedge w_clock);
    #1;
    chk(w_i_rdata === 32'h0, "abandoned_i_rdata", w_i_rdata, 32'h0);
    drive_i(2, 0);
    drive_d(2, 1, 2);

    repeat (4) @(posedge w_clock);
    #1;
    chk(iq.size() == 0 && dq.size() == 0, "drain", 32'(iq.size() + dq.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
